// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master) and memory (slave).
interface instr_fetch_unit_if;
    logic        o_imem_req_vld;
    logic        i_imem_req_rdy;
    logic [31:0] o_imem_addr;
    logic        i_imem_rsp_vld;
    logic [31:0] i_imem_rsp_data;

    modport master (
        output o_imem_req_vld, o_imem_addr,
        input  i_imem_req_rdy, i_imem_rsp_vld, i_imem_rsp_data
    );

    modport slave (
        input  o_imem_req_vld, o_imem_addr,
        output i_imem_req_rdy, i_imem_rsp_vld, i_imem_rsp_data
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Credit-based instruction fetcher with in-order response queue and redirect flush.
// Optional performance counters are built when the IFU_PERF_EN macro is defined.
module instr_fetch_unit #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MAX_OUTST = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_redirect,
    input  logic [31:0]               i_redirect_pc,
    instr_fetch_unit_if.master        imem,
    output logic                      o_instr_vld,
    output logic [31:0]               o_instr,
    output logic [31:0]               o_instr_pc,
    input  logic                      i_instr_rdy,
    output logic [31:0]               o_perf_instr,
    output logic [31:0]               o_perf_bubble
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } q_entry_t;

    q_entry_t      q_mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, outst, drop_cnt, outst_nxt;
    logic [31:0]   fetch_pc, rsp_pc;
    logic          req_vld, req_fire, rsp_fire, drop_rsp, enq, deq;

    always_comb begin
        // Credits cover both queued and in-flight entries so the queue can never overflow.
        req_vld   = !i_rst && !i_redirect && (outst < CW'(MAX_OUTST))
                    && (({1'b0, count} + {1'b0, outst}) < (CW+1)'(DEPTH));
        req_fire  = req_vld && imem.i_imem_req_rdy;
        rsp_fire  = !i_rst && imem.i_imem_rsp_vld && (outst != '0);
        drop_rsp  = rsp_fire && (i_redirect || (drop_cnt != '0));
        enq       = rsp_fire && !drop_rsp;
        o_instr_vld = !i_rst && !i_redirect && (count != '0);
        deq       = o_instr_vld && i_instr_rdy;
        outst_nxt = outst + CW'(req_fire) - CW'(rsp_fire);
    end

    assign imem.o_imem_req_vld = req_vld;
    assign imem.o_imem_addr    = i_rst ? RESET_PC : fetch_pc;
    assign o_instr             = o_instr_vld ? q_mem[rd_ptr].instr : 32'h0;
    assign o_instr_pc          = o_instr_vld ? q_mem[rd_ptr].pc    : 32'h0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            outst    <= '0;
            drop_cnt <= '0;
        end else begin
            outst <= outst_nxt;
            if (req_fire)
                fetch_pc <= fetch_pc + 32'd4;
            if (i_redirect) begin
                // Everything still in flight after this cycle belongs to the old stream.
                fetch_pc <= {i_redirect_pc[31:2], 2'b00};
                rsp_pc   <= {i_redirect_pc[31:2], 2'b00};
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                drop_cnt <= outst_nxt;
            end else begin
                if (drop_rsp)
                    drop_cnt <= drop_cnt - 1'b1;
                if (enq) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    rsp_pc <= rsp_pc + 32'd4;
                end
                if (deq)
                    rd_ptr <= rd_ptr + 1'b1;
                count <= count + CW'(enq) - CW'(deq);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (enq)
            q_mem[wr_ptr] <= '{pc: rsp_pc, instr: imem.i_imem_rsp_data};
    end

`ifdef IFU_PERF_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_perf_instr  <= 32'h0;
            o_perf_bubble <= 32'h0;
        end else begin
            if (deq)
                o_perf_instr <= o_perf_instr + 32'd1;
            if (!o_instr_vld)
                o_perf_bubble <= o_perf_bubble + 32'd1;
        end
    end
`else
    assign o_perf_instr  = 32'h0;
    assign o_perf_bubble = 32'h0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a behavioural in-order memory of programmable latency.
module tb_instr_fetch_unit;
    localparam logic [31:0] K = 32'hA5A5_0F0F;

    logic        i_clk = 1'b0;
    logic        i_rst, i_redirect, i_instr_rdy, o_instr_vld;
    logic [31:0] i_redirect_pc, o_instr, o_instr_pc, o_perf_instr, o_perf_bubble;

    instr_fetch_unit_if imem_if();

    instr_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0), .MAX_OUTST(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
        .imem(imem_if), .o_instr_vld(o_instr_vld), .o_instr(o_instr), .o_instr_pc(o_instr_pc),
        .i_instr_rdy(i_instr_rdy), .o_perf_instr(o_perf_instr), .o_perf_bubble(o_perf_bubble)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0, n_err = 0, lat = 1, cyc = 0, n_acc = 0;

    typedef struct { logic [31:0] a; int due; } mreq_t;
    mreq_t mq[$];

    // Memory: answers in order, data = addr ^ K, cleared whenever reset is sampled.
    initial begin
        logic acc, taken, rst_s;
        logic [31:0] aa;
        imem_if.i_imem_rsp_vld  = 1'b0;
        imem_if.i_imem_rsp_data = 32'h0;
        forever begin
            @(negedge i_clk);
            acc   = imem_if.o_imem_req_vld && imem_if.i_imem_req_rdy;
            aa    = imem_if.o_imem_addr;
            taken = imem_if.i_imem_rsp_vld;
            rst_s = i_rst;
            @(posedge i_clk);
            cyc++;
            if (rst_s) mq.delete();
            else begin
                if (taken && mq.size() > 0) void'(mq.pop_front());
                if (acc) begin mq.push_back('{aa, cyc + lat - 1}); n_acc++; end
            end
            #1;
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                imem_if.i_imem_rsp_vld = 1'b1; imem_if.i_imem_rsp_data = mq[0].a ^ K;
            end else begin
                imem_if.i_imem_rsp_vld = 1'b0; imem_if.i_imem_rsp_data = 32'h0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic next_cyc();
        @(posedge i_clk); #1;
    endtask

    task automatic do_reset();
        i_rst = 1'b1; i_redirect = 1'b0; i_redirect_pc = 32'h0;
        repeat (2) next_cyc();
        i_rst = 1'b0;
    endtask

    task automatic test_reset();
        lat = 1; imem_if.i_imem_req_rdy = 1'b1; i_instr_rdy = 1'b1;
        i_rst = 1'b1; i_redirect = 1'b1; i_redirect_pc = 32'h40;
        next_cyc();
        @(negedge i_clk);
        n_cmp++; if (imem_if.o_imem_req_vld !== 1'b0) begin n_err++; $display("FAIL rst_req_vld: got %0b want 0", imem_if.o_imem_req_vld); end
        n_cmp++; if (o_instr_vld !== 1'b0) begin n_err++; $display("FAIL rst_instr_vld: got %0b want 0", o_instr_vld); end
        n_cmp++; if (o_instr !== 32'h0 || o_instr_pc !== 32'h0) begin n_err++; $display("FAIL rst_instr: got %h/%h want 0/0", o_instr, o_instr_pc); end
        n_cmp++; if (imem_if.o_imem_addr !== 32'h0) begin n_err++; $display("FAIL rst_addr: got %h want 0", imem_if.o_imem_addr); end
        next_cyc();
        i_rst = 1'b0; i_redirect = 1'b0;
        @(negedge i_clk);
        n_cmp++; if (imem_if.o_imem_req_vld !== 1'b1 || imem_if.o_imem_addr !== 32'h0) begin n_err++; $display("FAIL post_rst_req: got %0b/%h want 1/0", imem_if.o_imem_req_vld, imem_if.o_imem_addr); end
        n_cmp++; if (o_instr_vld !== 1'b0 || o_instr_pc !== 32'h0) begin n_err++; $display("FAIL post_rst_vld: got %0b/%h want 0/0", o_instr_vld, o_instr_pc); end
        n_cmp++; if (o_perf_instr !== 32'h0 || o_perf_bubble !== 32'h0) begin n_err++; $display("FAIL post_rst_perf: got %h/%h want 0/0", o_perf_instr, o_perf_bubble); end
    endtask

    task automatic test_stream();
        lat = 1; imem_if.i_imem_req_rdy = 1'b1; i_instr_rdy = 1'b1;
        do_reset();
        @(negedge i_clk);
        n_cmp++; if (imem_if.o_imem_addr !== 32'h0 || o_instr_vld !== 1'b0) begin n_err++; $display("FAIL stream_c1: got %h/%0b want 0/0", imem_if.o_imem_addr, o_instr_vld); end
        next_cyc(); @(negedge i_clk);
        n_cmp++; if (imem_if.o_imem_addr !== 32'h4 || o_instr_vld !== 1'b0) begin n_err++; $display("FAIL stream_c2: got %h/%0b want 4/0", imem_if.o_imem_addr, o_instr_vld); end
        next_cyc();
        for (int i = 0; i < 8; i++) begin
            @(negedge i_clk);
            n_cmp++;
            if (o_instr_vld !== 1'b1 || o_instr_pc !== 32'(i*4) || o_instr !== (32'(i*4) ^ K)) begin
                n_err++; $display("FAIL stream_%0d: got %0b/%h/%h want 1/%h/%h", i, o_instr_vld, o_instr_pc, o_instr, 32'(i*4), 32'(i*4) ^ K);
            end
            next_cyc();
        end
    endtask

    task automatic test_stall();
        int a0;
        lat = 1; imem_if.i_imem_req_rdy = 1'b1; i_instr_rdy = 1'b0;
        do_reset();
        a0 = n_acc;
        repeat (20) next_cyc();
        @(negedge i_clk);
        n_cmp++; if (n_acc - a0 !== 4) begin n_err++; $display("FAIL stall_reqs: got %0d want 4", n_acc - a0); end
        n_cmp++; if (imem_if.o_imem_req_vld !== 1'b0) begin n_err++; $display("FAIL stall_req_vld: got %0b want 0", imem_if.o_imem_req_vld); end
        next_cyc();
        i_instr_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clk);
            n_cmp++;
            if (o_instr_vld !== 1'b1 || o_instr_pc !== 32'(i*4) || o_instr !== (32'(i*4) ^ K)) begin
                n_err++; $display("FAIL stall_q%0d: got %0b/%h/%h want 1/%h", i, o_instr_vld, o_instr_pc, o_instr, 32'(i*4));
            end
            next_cyc();
        end
    endtask

    task automatic test_redirect_drop();
        int steps;
        logic found;
        lat = 3; imem_if.i_imem_req_rdy = 1'b1; i_instr_rdy = 1'b0;
        do_reset();
        next_cyc(); next_cyc();
        imem_if.i_imem_req_rdy = 1'b0; i_redirect = 1'b1; i_redirect_pc = 32'h100;
        @(negedge i_clk);
        n_cmp++; if (o_instr_vld !== 1'b0 || imem_if.o_imem_req_vld !== 1'b0) begin n_err++; $display("FAIL drop_redir_cyc: got %0b/%0b want 0/0", o_instr_vld, imem_if.o_imem_req_vld); end
        next_cyc();
        i_redirect = 1'b0; imem_if.i_imem_req_rdy = 1'b1;
        @(negedge i_clk);
        n_cmp++; if (imem_if.o_imem_req_vld !== 1'b1 || imem_if.o_imem_addr !== 32'h100) begin n_err++; $display("FAIL drop_addr: got %0b/%h want 1/100", imem_if.o_imem_req_vld, imem_if.o_imem_addr); end
        found = 1'b0; steps = 0;
        for (int k = 0; k < 20; k++) begin
            if (!found) begin
                next_cyc(); steps++;
                @(negedge i_clk);
                if (o_instr_vld) found = 1'b1;
            end
        end
        n_cmp++; if (found !== 1'b1 || steps !== 4) begin n_err++; $display("FAIL drop_latency: got found=%0b steps=%0d want 1/4", found, steps); end
        n_cmp++; if (o_instr_pc !== 32'h100 || o_instr !== (32'h100 ^ K)) begin n_err++; $display("FAIL drop_first_pc: got %h/%h want 100/%h", o_instr_pc, o_instr, 32'h100 ^ K); end
    endtask

    task automatic test_redirect_wrap();
        lat = 1; imem_if.i_imem_req_rdy = 1'b1; i_instr_rdy = 1'b1;
        do_reset();
        repeat (4) next_cyc();
        i_redirect = 1'b1; i_redirect_pc = 32'h203;
        @(negedge i_clk);
        n_cmp++; if (o_instr_vld !== 1'b0 || imem_if.o_imem_req_vld !== 1'b0) begin n_err++; $display("FAIL wrap_redir_cyc: got %0b/%0b want 0/0", o_instr_vld, imem_if.o_imem_req_vld); end
        next_cyc();
        i_redirect = 1'b0;
        @(negedge i_clk);
        n_cmp++; if (imem_if.o_imem_req_vld !== 1'b1 || imem_if.o_imem_addr !== 32'h200) begin n_err++; $display("FAIL align_addr: got %0b/%h want 1/200", imem_if.o_imem_req_vld, imem_if.o_imem_addr); end
        next_cyc(); @(negedge i_clk);
        n_cmp++; if (imem_if.o_imem_addr !== 32'h204 || o_instr_vld !== 1'b0) begin n_err++; $display("FAIL align_next: got %h/%0b want 204/0", imem_if.o_imem_addr, o_instr_vld); end
        next_cyc(); @(negedge i_clk);
        n_cmp++; if (o_instr_vld !== 1'b1 || o_instr_pc !== 32'h200) begin n_err++; $display("FAIL redir_rsp_excl: got %0b/%h want 1/200", o_instr_vld, o_instr_pc); end
        next_cyc(); @(negedge i_clk);
        n_cmp++; if (o_instr_vld !== 1'b1 || o_instr_pc !== 32'h204) begin n_err++; $display("FAIL align_second: got %0b/%h want 1/204", o_instr_vld, o_instr_pc); end
        // Two redirects in consecutive cycles: the later one must win.
        next_cyc();
        i_redirect = 1'b1; i_redirect_pc = 32'h500;
        next_cyc();
        i_redirect_pc = 32'hFFFF_FFFF;
        @(negedge i_clk);
        n_cmp++; if (o_instr_vld !== 1'b0) begin n_err++; $display("FAIL b2b_vld: got %0b want 0", o_instr_vld); end
        next_cyc();
        i_redirect = 1'b0;
        @(negedge i_clk);
        n_cmp++; if (imem_if.o_imem_req_vld !== 1'b1 || imem_if.o_imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL b2b_addr: got %0b/%h want 1/fffffffc", imem_if.o_imem_req_vld, imem_if.o_imem_addr); end
        next_cyc(); @(negedge i_clk);
        n_cmp++; if (imem_if.o_imem_addr !== 32'h0) begin n_err++; $display("FAIL wrap_addr: got %h want 0", imem_if.o_imem_addr); end
        next_cyc(); @(negedge i_clk);
        n_cmp++; if (o_instr_vld !== 1'b1 || o_instr_pc !== 32'hFFFF_FFFC || o_instr !== (32'hFFFF_FFFC ^ K)) begin n_err++; $display("FAIL wrap_pc0: got %0b/%h/%h want 1/fffffffc", o_instr_vld, o_instr_pc, o_instr); end
        next_cyc(); @(negedge i_clk);
        n_cmp++; if (o_instr_vld !== 1'b1 || o_instr_pc !== 32'h0) begin n_err++; $display("FAIL wrap_pc1: got %0b/%h want 1/0", o_instr_vld, o_instr_pc); end
    endtask

    task automatic test_reset_inflight();
        int a0;
        lat = 3; imem_if.i_imem_req_rdy = 1'b1; i_instr_rdy = 1'b0;
        do_reset();
        repeat (3) next_cyc();
        i_rst = 1'b1;
        @(negedge i_clk);
        n_cmp++; if (imem_if.o_imem_req_vld !== 1'b0 || o_instr_vld !== 1'b0) begin n_err++; $display("FAIL inflight_rst: got %0b/%0b want 0/0", imem_if.o_imem_req_vld, o_instr_vld); end
        next_cyc(); next_cyc();
        i_rst = 1'b0;
        a0 = n_acc;
        @(negedge i_clk);
        n_cmp++; if (imem_if.o_imem_addr !== 32'h0 || o_instr_vld !== 1'b0) begin n_err++; $display("FAIL inflight_restart: got %h/%0b want 0/0", imem_if.o_imem_addr, o_instr_vld); end
        repeat (20) next_cyc();
        @(negedge i_clk);
        n_cmp++; if (n_acc - a0 !== 4) begin n_err++; $display("FAIL inflight_credits: got %0d want 4", n_acc - a0); end
        n_cmp++; if (o_instr_vld !== 1'b1 || o_instr_pc !== 32'h0) begin n_err++; $display("FAIL inflight_head: got %0b/%h want 1/0", o_instr_vld, o_instr_pc); end
    endtask

    task automatic test_perf();
        logic [31:0] exp_i, exp_b;
`ifdef IFU_PERF_EN
        exp_i = 32'd10; exp_b = 32'd5;
`else
        exp_i = 32'd0;  exp_b = 32'd0;
`endif
        lat = 1; imem_if.i_imem_req_rdy = 1'b1; i_instr_rdy = 1'b1;
        do_reset();
        repeat (10) next_cyc();
        imem_if.i_imem_req_rdy = 1'b0;
        repeat (5) next_cyc();
        @(negedge i_clk);
        n_cmp++; if (o_instr_vld !== 1'b0) begin n_err++; $display("FAIL perf_drained: got %0b want 0", o_instr_vld); end
        n_cmp++; if (o_perf_instr !== exp_i) begin n_err++; $display("FAIL perf_instr: got %0d want %0d", o_perf_instr, exp_i); end
        n_cmp++; if (o_perf_bubble !== exp_b) begin n_err++; $display("FAIL perf_bubble: got %0d want %0d", o_perf_bubble, exp_b); end
    endtask

    initial begin
        i_rst = 1'b1; i_redirect = 1'b0; i_redirect_pc = 32'h0; i_instr_rdy = 1'b1;
        imem_if.i_imem_req_rdy = 1'b1;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_drop();
        test_redirect_wrap();
        test_reset_inflight();
        test_perf();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, instruction queue depth; power of two, 2..16.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, fetch address after reset.
REQ-003 SHALL have parameter MAX_OUTST, default 4, maximum outstanding memory requests, 1..DEPTH.
REQ-004 SHALL have port i_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port i_rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port i_redirect, input, 1, flush and restart fetch at i_redirect_pc.
REQ-007 SHALL have port i_redirect_pc, input, 32, new fetch address.
REQ-008 SHALL have port o_imem_req_vld, output, 1, instruction-memory request valid.
REQ-009 SHALL have port i_imem_req_rdy, input, 1, memory accepts request.
REQ-010 SHALL have port o_imem_addr, output, 32, request word address.
REQ-011 SHALL have port i_imem_rsp_vld, input, 1, response valid; responses return in request order, any latency >= 1 cycle.
REQ-012 SHALL have port i_imem_rsp_data, input, 32, returned instruction.
REQ-013 SHALL have port o_instr_vld, output, 1, queue head valid.
REQ-014 SHALL have port o_instr, output, 32, queue head instruction.
REQ-015 SHALL have port o_instr_pc, output, 32, address of queue head instruction.
REQ-016 SHALL have port i_instr_rdy, input, 1, consumer takes head when o_instr_vld and i_instr_rdy are both high.
REQ-017 SHALL have ports o_perf_instr and o_perf_bubble, output, 32 each, performance counters (see Configuration).

Function
REQ-018 Request SHALL be accepted only in a cycle with o_imem_req_vld=1 and i_imem_req_rdy=1; no hold obligation across cycles.
REQ-019 o_imem_req_vld SHALL be high only if i_redirect=0 and outstanding < MAX_OUTST and (queue count + outstanding) < DEPTH (credit rule; the queue never overflows).
REQ-020 Fetch PC SHALL advance by 4 on each accepted request; arithmetic modulo 2^32, 32'hFFFF_FFFC wraps to 32'h0.
REQ-021 Non-dropped response SHALL be written to the queue tail with its request address; it becomes visible on o_instr_vld in the following cycle (1-cycle latency).
REQ-022 Enqueue and dequeue in the same cycle SHALL leave count unchanged; simultaneous accept and response SHALL leave outstanding unchanged.
REQ-023 On i_redirect=1: queue emptied, fetch PC <= {i_redirect_pc[31:2],2'b00}, drop counter <= outstanding after this cycle's request and response accounting; o_instr_vld SHALL be forced 0 that cycle, so no dequeue occurs.
REQ-024 While drop counter > 0, each response SHALL be discarded and decrement the drop counter and outstanding.
REQ-025 A response arriving in the redirect cycle SHALL be discarded and excluded from the drop counter.
REQ-026 Back-to-back redirects SHALL each take effect; the last one sets the fetch PC.
REQ-027 With DEPTH full and i_instr_rdy=0, the block SHALL stall with no request issued and no data lost.

Reset
REQ-028 While i_rst=1 at a clock edge: fetch PC <= RESET_PC, queue empty, outstanding <= 0, drop counter <= 0, perf counters <= 0.
REQ-029 In the cycle after reset and throughout reset: o_imem_req_vld=0, o_instr_vld=0, o_instr=0, o_instr_pc=0; o_imem_addr=RESET_PC.
REQ-030 Reset SHALL take priority over i_redirect; responses arriving while i_rst=1 SHALL be ignored; the memory is reset alongside the block.

Configuration
REQ-031 Macro IFU_PERF_EN defined: o_perf_instr SHALL count dequeues; o_perf_bubble SHALL count non-reset cycles with o_instr_vld=0; both wrap at 2^32.
REQ-032 Macro IFU_PERF_EN undefined: counter logic SHALL be absent and both ports tied to 32'h0.

Verification
REQ-033 Reset, memory always ready, 1-cycle latency, i_instr_rdy=1 -> addresses 0x0,0x4,0x8...; first o_instr_vld at cycle 3 after reset release, then 1 instruction per cycle.
REQ-034 i_instr_rdy=0 for 20 cycles, DEPTH=4 -> exactly 4 requests issued, queue holds 0x0..0xC in order, o_imem_req_vld=0 thereafter.
REQ-035 Latency 3, MAX_OUTST=4, redirect to 0x100 with 2 requests in flight -> 2 responses dropped; next o_instr_pc=0x100.
REQ-036 Redirect to 0x203 -> o_imem_addr=0x200; redirect to 0xFFFF_FFFC -> next addresses 0xFFFF_FFFC, 0x0.
REQ-037 i_rst asserted with 3 requests in flight, then released -> fetch restarts at RESET_PC; stale responses are not enqueued.
REQ-038 IFU_PERF_EN defined, 10 dequeues plus 5 empty cycles -> o_perf_instr=10, o_perf_bubble=5; IFU_PERF_EN undefined -> both 0.
